// File: rtl/vga_sync_monitor.sv
`timescale 1ns/1ps
// vga_sync_monitor: receive-side VGA timing checker. Rebuilds the raster
// position from hsync/vsync, flags timing violations, tracks lock and emits
// decoded visible pixels. Outputs trail the sampled inputs by two edges.
module vga_sync_monitor #(
  parameter int H_ACTIVE        = 640,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int H_TOTAL         = 800,
  parameter int V_ACTIVE        = 480,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int V_TOTAL         = 525,
  parameter int LOCK_FRAMES     = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [2:0] rgb_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [2:0] pixel_rgb,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err,
  output logic [7:0] err_count
);
  localparam logic [9:0]  HV0    = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  HV1    = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  VV0    = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VV1    = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] HSW    = 11'(H_SYNC);
  localparam logic [10:0] HTOT   = 11'(H_TOTAL);
  localparam logic [10:0] VTOT   = 11'(V_TOTAL);
  localparam logic [10:0] TMO    = 11'(2 * H_TOTAL);
  localparam logic [3:0]  VSW    = 4'(V_SYNC);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

  // one sampled video beat, sync already normalised to active-high
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } smp_t;

  typedef enum logic [1:0] {UNLOCKED, COUNTING, LOCKED} lock_t;

  smp_t        s1, s2;          // s2 is s1 one beat later: edge reference, rgb aligned to h
  logic        hs_n, vs_n;
  logic        hs_rise, hs_fall, vs_rise, vs_fall;
  logic [9:0]  h, v;
  logic [3:0]  vcnt;            // hsync edges seen while vsync asserted
  logic [10:0] gap, gap_nxt;    // unsaturated-to-1023 view of h for the timeout
  logic        h_ref, v_ref, to_arm;
  logic        err_hw, err_ll, err_vw, err_fl, err_to, err_any;
  logic        err_q, fs_q;
  logic        vis;
  lock_t       st, st_n;
  logic [7:0]  clean, clean_n;

  assign hs_n    = (SYNC_ACTIVE_LOW != 0) ? ~hsync_in : hsync_in;
  assign vs_n    = (SYNC_ACTIVE_LOW != 0) ? ~vsync_in : vsync_in;
  assign hs_rise =  s1.hs & ~s2.hs;
  assign hs_fall = ~s1.hs &  s2.hs;
  assign vs_rise =  s1.vs & ~s2.vs;
  assign vs_fall = ~s1.vs &  s2.vs;

  // input sampling and one-beat history for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {hs_n, vs_n, rgb_in};
      s2 <= s1;
    end
  end

  // timing checks, evaluated against the counters before they update
  always_comb begin
    gap_nxt = hs_rise ? 11'd0 : ((gap == 11'h7FF) ? gap : gap + 11'd1);
    err_hw  = hs_fall & h_ref & (({1'b0, h} + 11'd1) != HSW);
    err_ll  = hs_rise & h_ref & (({1'b0, h} + 11'd1) != HTOT);
    err_vw  = vs_fall & v_ref & (vcnt != VSW);
    err_fl  = vs_rise & v_ref & (({1'b0, v} + 11'd1) != VTOT);
    err_to  = to_arm & (gap_nxt == TMO);
    err_any = err_hw | err_ll | err_vw | err_fl | err_to;
  end

  // raster counters, reference flags and timeout arming
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h      <= '0;
      v      <= '0;
      vcnt   <= '0;
      gap    <= '0;
      h_ref  <= 1'b0;
      v_ref  <= 1'b0;
      to_arm <= 1'b1;
      err_q  <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      h   <= hs_rise ? 10'd0 : ((h == 10'h3FF) ? h : h + 10'd1);
      gap <= gap_nxt;
      // vsync edge wins over a coincident hsync edge
      if (vs_rise)                    v <= '0;
      else if (hs_rise && v != 10'h3FF) v <= v + 10'd1;
      if (vs_rise)                                 vcnt <= {3'b000, hs_rise};
      else if (s1.vs && hs_rise && vcnt != 4'hF)   vcnt <= vcnt + 4'd1;
      if (hs_rise) h_ref <= 1'b1;
      if (vs_rise) v_ref <= 1'b1;
      if (hs_rise)     to_arm <= 1'b1;
      else if (err_to) to_arm <= 1'b0;
      err_q <= err_any;
      fs_q  <= vs_rise;
    end
  end

  // lock state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= UNLOCKED;
      clean <= '0;
    end else begin
      st    <= st_n;
      clean <= clean_n;
    end
  end

  // lock next state: any error drops lock, the following vsync edge restarts counting
  always_comb begin
    st_n    = st;
    clean_n = clean;
    if (err_any) begin
      st_n    = UNLOCKED;
      clean_n = '0;
    end else if (vs_rise) begin
      unique case (st)
        UNLOCKED: begin
          st_n    = COUNTING;
          clean_n = '0;
        end
        COUNTING: begin
          clean_n = clean + 8'd1;
          if (clean_n == LOCK_N) st_n = LOCKED;
        end
        default: ;
      endcase
    end
  end

  assign vis = (h >= HV0) && (h < HV1) && (v >= VV0) && (v < VV1);

  // output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_rgb   <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      err_count   <= '0;
    end else begin
      pixel_x     <= vis ? h - HV0 : 10'd0;
      pixel_y     <= vis ? v - VV0 : 10'd0;
      pixel_rgb   <= vis ? s2.rgb : 3'd0;
      pixel_valid <= (st == LOCKED) & vis;
      frame_start <= fs_q;
      locked      <= (st == LOCKED);
      timing_err  <= err_q;
      if (err_q && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_vga_sync_monitor.sv
`timescale 1ns/1ps
// tb_vga_sync_monitor: scaled-raster generator drives the monitor; expected
// outputs are queued per driven beat and compared three negedges later.
module tb_vga_sync_monitor;
  localparam int HA = 16, HS = 4, HB = 4, HT = 32;
  localparam int VA = 6,  VS = 2, VB = 2, VT = 12;

  logic       clk = 1'b0, reset = 1'b0;
  logic       hsync_in = 1'b1, vsync_in = 1'b1;
  logic [2:0] rgb_in = '0;
  logic [9:0] pixel_x, pixel_y;
  logic [2:0] pixel_rgb;
  logic       pixel_valid, frame_start, locked, timing_err;
  logic [7:0] err_count;

  vga_sync_monitor #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .LOCK_FRAMES(2), .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rgb_in(rgb_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_rgb(pixel_rgb), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pchk, lkchk;
    logic       pv, fs, lk, te;
    logic [9:0] x, y;
    logic [2:0] rgb;
    logic [7:0] ec;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  int   gh = 0, gv = 0, lt = HT, hw = HS, vw = VS;
  int   nfs = 0, ec_m = 0;
  bit   pvs = 1'b0, synced = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp(input exp_t e);
    chk("te", 32'(timing_err), 32'(e.te));
    chk("ec", 32'(err_count), 32'(e.ec));
    chk("fs", 32'(frame_start), 32'(e.fs));
    if (e.lkchk) chk("lk", 32'(locked), 32'(e.lk));
    if (e.pchk) begin
      chk("pv",  32'(pixel_valid), 32'(e.pv));
      chk("px",  32'(pixel_x),     32'(e.x));
      chk("py",  32'(pixel_y),     32'(e.y));
      chk("rgb", 32'(pixel_rgb),   32'(e.rgb));
    end
  endtask

  // drive one beat (sync levels active-high here, inverted on the wire)
  task automatic step(input bit hs_a, input bit vs_a, input bit e_te, input bit pchk);
    exp_t e;
    bit   vis;
    @(negedge clk);
    if (q.size() == 3) cmp(q.pop_front());
    hsync_in = ~hs_a;
    vsync_in = ~vs_a;
    rgb_in   = gh[2:0];
    e.fs = vs_a & ~pvs;
    pvs  = vs_a;
    if (e.fs) begin
      synced = 1'b1;
      if (nfs < 3) nfs++;
    end
    if (e_te) begin
      nfs = 0;
      if (ec_m < 255) ec_m++;
    end
    e.te    = e_te;
    e.ec    = 8'(ec_m);
    e.lk    = (nfs >= 3);
    e.lkchk = !e_te;
    vis = (gh >= HS + HB) && (gh < HS + HB + HA) && (gv >= VS + VB) && (gv < VS + VB + VA);
    e.pchk = pchk & synced;
    e.pv   = e.lk & vis;
    e.x    = vis ? 10'(gh - HS - HB) : 10'd0;
    e.y    = vis ? 10'(gv - VS - VB) : 10'd0;
    e.rgb  = vis ? 3'(gh % 8) : 3'd0;
    q.push_back(e);
  endtask

  task automatic gcyc(input bit e_te);
    step(gh < hw, gv < vw, e_te, 1'b1);
    gh++;
    if (gh >= lt) begin
      gh = 0;
      gv = (gv + 1) % VT;
    end
  endtask

  task automatic run_to(input int v, input int h);
    while (!(gv == v && gh == h)) gcyc(1'b0);
  endtask

  task automatic relock();
    repeat (4) begin
      gcyc(1'b0);
      run_to(0, 0);
    end
  endtask

  // reset asserted between clock edges; outputs must clear without a clock
  task automatic rst_async();
    #2 reset = 1'b1;
    #1;
    chk("rst_px",  32'(pixel_x), 0);
    chk("rst_py",  32'(pixel_y), 0);
    chk("rst_rgb", 32'(pixel_rgb), 0);
    chk("rst_pv",  32'(pixel_valid), 0);
    chk("rst_fs",  32'(frame_start), 0);
    chk("rst_lk",  32'(locked), 0);
    chk("rst_te",  32'(timing_err), 0);
    chk("rst_ec",  32'(err_count), 0);
    q.delete();
    nfs = 0; ec_m = 0; pvs = 1'b0; synced = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_lk", 32'(locked), 0);
    chk("rst_hold_ec", 32'(err_count), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_async();

    // nominal frames: lock on third frame_start
    relock();

    // one line one clock long
    run_to(5, 0);
    lt = HT + 1;
    repeat (HT + 1) gcyc(1'b0);
    lt = HT;
    gcyc(1'b1);
    relock();

    // hsync pulse one clock short
    run_to(3, 0);
    hw = HS - 1;
    repeat (HS - 1) gcyc(1'b0);
    gcyc(1'b1);
    hw = HS;

    // vsync pulse one line long
    run_to(0, 0);
    vw = VS + 1;
    run_to(VS + 1, 0);
    gcyc(1'b1);
    vw = VS;
    relock();

    // reset mid visible line, then reacquire
    run_to(6, 12);
    gcyc(1'b0);
    rst_async();
    relock();

    // hsync stuck deasserted: single timeout at 2*HT beats after last edge
    run_to(4, 0);
    for (int s = 0; s < 200; s++) step(1'b0, 1'b0, s == HT, 1'b0);

    // error storm: 1-beat hsync on 4-beat lines, two errors per line
    for (int l = 0; l < 150; l++)
      for (int k = 0; k < 4; k++) step(k == 0, 1'b0, k < 2, 1'b0);

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
